spi_axis_packer: RTL
====================

// Module: spi_axis_packer
// PURPOSE
// - Successor SPI-slave RX bridge: drives iCE40 SB_SPI system bus, drains SPIRXDR bytes, packs them little-endian into DATA_W-bit words.
// - Buffers packed words in a FIFO and presents them as AXI-Stream with tkeep/tlast framing.
// - Sits between the top-level SB_SPI instance and the pixel stream input of the Sobel pipeline.
// - Adds what the 8-bit bridge lacks: width packing, buffering/backpressure, packet and idle-timeout framing, back-to-back byte draining.
// PARAMETERS
// DATA_W        32    stream width; multiple of 8, >= 8
// FIFO_DEPTH    8     packed-word FIFO entries; power of 2, >= 2
// PKT_BYTES     0     bytes per packet for tlast; 0 = packet framing disabled
// TIMEOUT_CYC   1024  idle cycles before a partial word is flushed; 0 = disabled
// RX_ADDR_P     8'h0E SPIRXDR address
// IRQ_ADDR_P    8'h06 SPIIRQ address
// IRQ_RRDY_BIT_P 3    RRDY bit index in SPIIRQ
// PORTS
// clk_i        in   1              core clock
// rstn_i       in   1              reset, asynchronous, active-low
// spiirq_i     in   1              SB_SPI interrupt
// sback_i      in   1              SB bus ack, 1-cycle pulse; sbdato_i valid with it
// sbdato_i     in   8              SB read data
// sbrwi_o      out  1              1 = write, 0 = read
// sbstbi_o     out  1              SB strobe
// sbadri_o     out  8              SB address
// sbdati_o     out  8              SB write data
// tdata_o      out  DATA_W         stream payload, byte 0 = first received
// tkeep_o      out  DATA_W/8       valid bytes (contiguous from LSB)
// tstrb_o      out  DATA_W/8       equals tkeep_o
// tlast_o      out  1              end of packet
// tvalid_o     out  1              FIFO not empty
// tready_i     in   1              sink ready
// fifo_level_o out  $clog2(FIFO_DEPTH)+1  words held
// busy_o       out  1              FSM not in IDLE
// BEHAVIOUR
// - Reset (async, rstn_i low): FSM=IDLE, pack reg/byte idx/pkt cnt/timeout cnt cleared, FIFO empty; all outputs 0 except tkeep_o/tstrb_o = 0 while empty. Reset mid-transaction drops strobe immediately, discards partial word.
// - SB bus: in a bus state, sbstbi_o=1 with addr/data/rw held until sback_i; strobe deasserted in ack cycle; all SB outputs 0 outside bus states.
// - FSM: IDLE -> CHECK_IRQ when spiirq_i && FIFO not full.
//   CHECK_IRQ: read IRQ_ADDR_P; on ack RRDY=1 -> READ_DATA, else -> CLEAR_IRQ.
//   READ_DATA: read RX_ADDR_P; on ack byte enters pack reg -> CLEAR_IRQ.
//   CLEAR_IRQ: write IRQ_ADDR_P data 1<<IRQ_RRDY_BIT_P; on ack -> CHECK_IRQ if spiirq_i && FIFO not full, else IDLE.
//   Illegal state -> IDLE.
// - Full FIFO never entered from IDLE/CLEAR_IRQ; one byte completes at most one word, so no accepted byte is ever dropped.
// - Packing: byte k of word at bits [8k+7:8k]; word pushed when byte idx = DATA_W/8-1, or packet end, or timeout. Push latency: byte ack at edge N, word visible on tvalid_o after edge N+1.
// - Packet: PKT_BYTES>0: counter increments per byte; on byte PKT_BYTES push current (possibly partial) word with tlast=1, counter and idx reset to 0.
// - Timeout: counter runs while partial word held and no byte arrives; at TIMEOUT_CYC push partial word, tkeep = bytes held, tlast=1; packet counter also resets. Full words never flagged by timeout.
// - Stream: FWFT; tdata/tkeep/tlast stable while tvalid_o && !tready_i; pop on tvalid_o && tready_i.
// - Simultaneous push and pop: both occur, level unchanged; push into full FIFO impossible by construction (assert).
// - Pointers wrap modulo FIFO_DEPTH; level = 0..FIFO_DEPTH.
// TESTING
// - DATA_W=32, send 8'h11,22,33,44 -> one beat tdata=32'h44332211, tkeep=4'hF, tlast=0.
// - PKT_BYTES=6, bytes 01..06 -> beat 32'h04030201 keep F last 0, beat 32'h00000605 keep 3 last 1.
// - TIMEOUT_CYC=16, send AA,BB then idle -> after 16 idle cycles beat 32'h0000BBAA keep 3 last 1.
// - tready_i=0, 40 bytes, FIFO_DEPTH=8 -> level reaches 8, FSM stalls in IDLE with spiirq_i high; release -> all 10 words in order, no loss.
// - SPIIRQ read returns RRDY=0 -> CLEAR_IRQ write sbdati_o=8'h08 sbrwi_o=1, no stream beat.
// - Assert rstn_i during READ_DATA strobe -> sbstbi_o low same cycle, tvalid_o=0, fifo_level_o=0.

Source files
------------

// File: rtl/spi_axis_packer_if.sv
// SB_SPI system-bus and AXI-Stream signal bundle for the SPI RX packer.
// The master modport is the packer side, the slave modport is the SB_SPI/sink side.
interface spi_axis_packer_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  spiirq_i;
  logic                  sback_i;
  logic [7:0]            sbdato_i;
  logic                  sbrwi_o;
  logic                  sbstbi_o;
  logic [7:0]            sbadri_o;
  logic [7:0]            sbdati_o;
  logic [DATA_W-1:0]     tdata_o;
  logic [DATA_W/8-1:0]   tkeep_o;
  logic [DATA_W/8-1:0]   tstrb_o;
  logic                  tlast_o;
  logic                  tvalid_o;
  logic                  tready_i;

  modport master (
    input  spiirq_i, sback_i, sbdato_i, tready_i,
    output sbrwi_o, sbstbi_o, sbadri_o, sbdati_o, tdata_o, tkeep_o, tstrb_o, tlast_o, tvalid_o
  );

  modport slave (
    output spiirq_i, sback_i, sbdato_i, tready_i,
    input  sbrwi_o, sbstbi_o, sbadri_o, sbdati_o, tdata_o, tkeep_o, tstrb_o, tlast_o, tvalid_o
  );
endinterface

// File: rtl/spi_axis_packer.sv
// SPI-slave RX bridge: drains SB_SPI RX bytes, packs them little-endian into DATA_W words,
// buffers them in a FIFO and emits AXI-Stream beats with tkeep/tlast framing.
module spi_axis_packer #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned PKT_BYTES      = 0,
  parameter int unsigned TIMEOUT_CYC    = 1024,
  parameter logic [7:0]  RX_ADDR_P      = 8'h0E,
  parameter logic [7:0]  IRQ_ADDR_P     = 8'h06,
  parameter int unsigned IRQ_RRDY_BIT_P = 3
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  spi_axis_packer_if.master             bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned IdxW    = $clog2(NB + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EW      = DATA_W + NB + 1;
  localparam logic [31:0] ToLast  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
  localparam logic [15:0] PktLast = 16'(PKT_BYTES);
  localparam logic [7:0]  RrdyMsk = 8'(1 << IRQ_RRDY_BIT_P);
  localparam logic [AW:0] DepthL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCheckIrq, StReadData, StClearIrq} state_e;

  state_e            r_state;
  logic              r_stb, r_rw;
  logic [7:0]        r_adr, r_dat;
  logic [DATA_W-1:0] r_pack;
  logic [IdxW-1:0]   r_idx;
  logic [15:0]       r_pkt_cnt;
  logic [31:0]       r_to_cnt;
  logic              r_push, r_push_last;
  logic [NB-1:0]     r_push_keep;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;

  logic [AW:0]       w_level;
  logic              w_full, w_empty, w_pop, w_go, w_byte, w_pkt_end, w_word_end;
  logic              w_to_run, w_to_fire;
  logic [IdxW-1:0]   w_idx_nx;
  logic [15:0]       w_cnt_nx;
  logic [EW-1:0]     w_head;

  function automatic logic [NB-1:0] f_keep(input logic [IdxW-1:0] n);
    logic [NB-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < NB; i++) k[i] = (i < 32'(n));
    return k;
  endfunction

  assign w_level    = r_wptr - r_rptr;
  assign w_full     = (w_level == DepthL);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_pop      = !w_empty && bus.tready_i;
  assign w_go       = bus.spiirq_i && !w_full;
  assign w_byte     = (r_state == StReadData) && r_stb && bus.sback_i;
  assign w_idx_nx   = r_idx + 1'b1;
  assign w_cnt_nx   = r_pkt_cnt + 16'd1;
  assign w_pkt_end  = (PKT_BYTES != 0) && (w_cnt_nx == PktLast);
  assign w_word_end = (w_idx_nx == IdxW'(NB));
  // Idle counter only runs while a partial word is held and the FIFO can take it.
  assign w_to_run   = (TIMEOUT_CYC != 0) && (r_idx != '0) && !w_full;
  assign w_to_fire  = w_to_run && (r_to_cnt == ToLast);
  assign w_head     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= StIdle;
      r_stb       <= 1'b0;
      r_rw        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_pack      <= '0;
      r_idx       <= '0;
      r_pkt_cnt   <= '0;
      r_to_cnt    <= '0;
      r_push      <= 1'b0;
      r_push_keep <= '0;
      r_push_last <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_push) r_pack <= '0;

      if (w_byte) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (r_idx == IdxW'(b)) r_pack[8*b +: 8] <= bus.sbdato_i;
        end
        r_to_cnt  <= '0;
        r_pkt_cnt <= (w_pkt_end || PKT_BYTES == 0) ? '0 : w_cnt_nx;
        if (w_word_end || w_pkt_end) begin
          r_push      <= 1'b1;
          r_push_keep <= f_keep(w_idx_nx);
          r_push_last <= w_pkt_end;
          r_idx       <= '0;
        end else begin
          r_idx <= w_idx_nx;
        end
      end else if (w_to_fire) begin
        r_push      <= 1'b1;
        r_push_keep <= f_keep(r_idx);
        r_push_last <= 1'b1;
        r_idx       <= '0;
        r_pkt_cnt   <= '0;
        r_to_cnt    <= '0;
      end else if (w_to_run) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end else begin
        r_to_cnt <= '0;
      end

      // Strobe is raised on entry to a bus state and held until the ack is sampled.
      unique case (r_state)
        StIdle: begin
          if (w_go) begin
            r_state <= StCheckIrq;
            r_stb   <= 1'b1;
            r_adr   <= IRQ_ADDR_P;
          end
        end
        StCheckIrq: begin
          if (bus.sback_i) begin
            if (bus.sbdato_i[IRQ_RRDY_BIT_P]) begin
              r_state <= StReadData;
              r_adr   <= RX_ADDR_P;
            end else begin
              r_state <= StClearIrq;
              r_rw    <= 1'b1;
              r_dat   <= RrdyMsk;
            end
          end
        end
        StReadData: begin
          if (bus.sback_i) begin
            r_state <= StClearIrq;
            r_adr   <= IRQ_ADDR_P;
            r_rw    <= 1'b1;
            r_dat   <= RrdyMsk;
          end
        end
        StClearIrq: begin
          if (bus.sback_i) begin
            r_rw  <= 1'b0;
            r_dat <= '0;
            if (w_go) begin
              r_state <= StCheckIrq;
            end else begin
              r_state <= StIdle;
              r_stb   <= 1'b0;
              r_adr   <= '0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_stb   <= 1'b0;
          r_rw    <= 1'b0;
          r_adr   <= '0;
          r_dat   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_push) r_mem[r_wptr[AW-1:0]] <= {r_push_last, r_push_keep, r_pack};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (r_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  no_push_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i) !(r_push && w_full));

  assign bus.sbstbi_o = r_stb && !bus.sback_i;
  assign bus.sbrwi_o  = r_rw;
  assign bus.sbadri_o = r_adr;
  assign bus.sbdati_o = r_dat;
  assign bus.tvalid_o = !w_empty;
  assign bus.tdata_o  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign bus.tkeep_o  = w_empty ? '0 : w_head[DATA_W +: NB];
  assign bus.tstrb_o  = bus.tkeep_o;
  assign bus.tlast_o  = !w_empty && w_head[EW-1];
  assign fifo_level_o = w_level;
  assign busy_o       = (r_state != StIdle);

endmodule
